// File: rtl/axi_burst_master.sv
// axi_burst_master
//   Single-outstanding AXI burst master. A user command (address, AXI length,
//   ID, direction) is turned into one AW/W/B or AR/R burst. Write data is
//   streamed straight from the user port to the W channel. Read data is
//   streamed straight from the R channel to the user port.
//
// Ports
//   clk, rst (async, active low)
//   cmd_*          command handshake and fields
//   wr_*           user write-data stream (wr_ready mirrors wready)
//   rd_*           user read-data stream, no backpressure
//   done           one-cycle pulse at burst end
//   resp/len_err/timeout  burst status, held until next done
//   aw*/w*/b*/ar*/r*      AXI master channels
//
// Build option
//   AXI_TIMEOUT_EN : adds a watchdog. Any state other than IDLE that sees
//                    neither a handshake nor a state change for TIMEOUT_CYC
//                    cycles aborts with resp=2'b11 and timeout=1.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WADDR | presenting AW
// WDATA | forwarding write beats
// WRESP | waiting for B
// RADDR | presenting AR
// RDATA | forwarding read beats until rlast
module axi_burst_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        resp,
  output logic              len_err,
  output logic              timeout,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [ID_W-1:0]   awid,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  input  logic [ID_W-1:0]   bid,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid
);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [ID_W-1:0]   id_q;
  logic [4:0]        beat;
  logic [1:0]        worst_q;
  logic [1:0]        r_worst;
  logic [1:0]        fin_resp;
  logic              fin_len_err;
  logic              beat_is_last;
  logic              fin;
  logic              tmo_fire;
  logic              done_q;
  logic [1:0]        resp_q;
  logic              len_err_q;

  // Read IDs are not checked; only one burst is ever outstanding.
  logic unused_rid;
  assign unused_rid = ^rid;

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arid    = id_q;
  assign wdata   = wr_data;
  assign rd_data = rdata;
  assign done    = done_q;
  assign resp    = resp_q;
  assign len_err = len_err_q;

  // The beat counter holds the number of beats already accepted, so the
  // current beat is the last one when the counter equals len.
  assign beat_is_last = (beat == {1'b0, len_q});
  assign r_worst      = (rresp > worst_q) ? rresp : worst_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wr_ready   = 1'b0;
    wlast      = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? WADDR : RADDR;
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) state_next = WDATA;
      end
      WDATA: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = beat_is_last;
        if (wr_valid && wready && beat_is_last) state_next = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_next = IDLE;
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_next = RDATA;
      end
      RDATA: begin
        rready   = 1'b1;
        rd_valid = rvalid;
        rd_last  = rlast;
        if (rvalid && rlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (tmo_fire) state_next = IDLE;
  end

  assign fin = (state == WRESP && bvalid) || (state == RDATA && rvalid && rlast) || tmo_fire;

  always_comb begin
    fin_resp    = r_worst;
    fin_len_err = 1'b0;
    if (tmo_fire)            fin_resp = 2'b11;
    else if (state == WRESP) fin_resp = (bid != id_q) ? 2'b10 : bresp;
    else                     fin_len_err = !beat_is_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      beat      <= '0;
      worst_q   <= '0;
      done_q    <= 1'b0;
      resp_q    <= '0;
      len_err_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (state == IDLE && cmd_valid) begin
        addr_q  <= cmd_addr;
        len_q   <= cmd_len;
        id_q    <= cmd_id;
        beat    <= '0;
        worst_q <= '0;
      end
      if (state == WDATA && wr_valid && wready) beat <= beat + 5'd1;
      if (state == RDATA && rvalid) begin
        // Saturate so a runaway slave cannot wrap the count back onto len.
        if (beat != 5'd31) beat <= beat + 5'd1;
        worst_q <= r_worst;
      end
      if (fin) begin
        resp_q    <= fin_resp;
        len_err_q <= fin_len_err;
      end
    end
  end

`ifdef AXI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          hs_any;
  logic          timeout_q;

  assign hs_any = (state == WADDR && awready) || (state == WDATA && wr_valid && wready) ||
                  (state == WRESP && bvalid)  || (state == RADDR && arready) ||
                  (state == RDATA && rvalid);
  // Fires on the TIMEOUT_CYC-th idle cycle of a state; done follows one cycle later.
  assign tmo_fire = (state != IDLE) && !hs_any && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign timeout  = timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE || hs_any || state_next != state) tmo_cnt <= '0;
      else                                               tmo_cnt <= tmo_cnt + 1'b1;
      if (fin) timeout_q <= tmo_fire;
    end
  end
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
module tb_axi_burst_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0;
  logic [3:0] cmd_len = 0, cmd_id = 0;
  logic [7:0] wr_data = 0;
  logic       wr_valid = 0, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, rd_last, done, len_err, timeout;
  logic [1:0] resp;
  logic       awvalid, awready = 0;
  logic [7:0] awaddr;
  logic [3:0] awlen, awid;
  logic       wvalid, wready = 0, wlast;
  logic [7:0] wdata;
  logic       bvalid = 0, bready;
  logic [1:0] bresp = 0;
  logic [3:0] bid = 0;
  logic       arvalid, arready = 0;
  logic [7:0] araddr;
  logic [3:0] arlen, arid;
  logic       rvalid = 0, rready, rlast = 0;
  logic [7:0] rdata = 0;
  logic [1:0] rresp = 0;
  logic [3:0] rid = 0;

  always #5 clk = ~clk;

  axi_burst_master #(.ADDR_W(8), .DATA_W(8), .ID_W(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .done(done), .resp(resp), .len_err(len_err), .timeout(timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  typedef struct { int kind; logic [31:0] val; } exp_t;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [1:0] last_resp = 2'b00;
  logic [7:0] wd  [16];
  logic [7:0] rdv [16];
  logic [1:0] rrv [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic fail_to(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic push(input int k, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int k, input logic [31:0] v, input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unexpected event 0x%0h, expected none", name, v);
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, k, e.kind);
      chk(name, v, e.val);
    end
  endtask

  // Monitor: every DUT-presented event pops the scoreboard in order.
  always @(negedge clk) begin
    if (rst) begin
      if (awvalid && awready) pop_chk(0, {16'h0, awid, awlen, awaddr}, "aw");
      if (wvalid && wready)   pop_chk(1, {23'h0, wlast, wdata}, "w_beat");
      if (arvalid && arready) pop_chk(2, {16'h0, arid, arlen, araddr}, "ar");
      if (rd_valid)           pop_chk(3, {23'h0, rd_last, rd_data}, "rd_beat");
      if (done)               pop_chk(4, {28'h0, timeout, len_err, resp}, "done");
    end
  end

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) fail_to(name);
    @(posedge clk); #1;
  endtask

  task automatic issue_cmd(input bit wr, input logic [7:0] addr, input logic [3:0] len,
                           input logic [3:0] id);
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("resp_held", resp, last_resp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input int aw_delay, input bit toggle, input logic [1:0] br,
                          input logic [3:0] b_id, input logic [1:0] exp_resp,
                          input int abort_beat, input bit no_b);
    bit hs;
    int beat;
    int bcnt;
    push(0, {16'h0, id, len, addr});
    for (int i = 0; i <= int'(len); i++)
      if (abort_beat < 0 || i < abort_beat) push(1, {23'h0, (i == int'(len)), wd[i]});
    if (abort_beat < 0) push(4, {28'h0, no_b, 1'b0, exp_resp});
    issue_cmd(1'b1, addr, len, id);
    hs = 0;
    for (int cyc = 0; cyc < 100 && !hs; cyc++) begin
      awready = (cyc >= aw_delay);
      @(negedge clk);
      chk("aw_stable", {awvalid, awaddr, awlen, awid}, {1'b1, addr, len, id});
      if (cyc == 0) chk("cmd_ready_busy", cmd_ready, 0);
      hs = awready;
      @(posedge clk); #1;
    end
    awready = 1'b0;
    if (!hs) fail_to("aw_handshake");
    beat = 0;
    for (int cyc = 0; cyc < 200 && beat <= int'(len); cyc++) begin
      wr_valid = 1'b1;
      wr_data  = wd[beat];
      wready   = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (beat == abort_beat) begin
        #2 rst = 1'b0;
        #1;
        chk("rst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid}, 0);
        chk("rst_status", {done, resp, len_err, timeout}, 0);
        wr_valid = 1'b0; wready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("no_done_after_rst", {done, cmd_ready, awvalid, wvalid}, 4'b0100);
        end
        @(posedge clk); #1;
        last_resp = 2'b00;
        return;
      end
      @(negedge clk);
      hs = wr_ready;
      @(posedge clk); #1;
      if (hs) beat++;
    end
    wr_valid = 1'b0;
    wready   = 1'b0;
    if (beat <= int'(len)) fail_to("w_beats");
    if (!no_b) begin
      bvalid = 1'b1; bresp = br; bid = b_id;
      hs = 0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk);
        hs = bready;
        @(posedge clk); #1;
      end
      bvalid = 1'b0;
      if (!hs) fail_to("b_handshake");
      wait_done("write_done");
    end else begin
      bcnt = 0;
      hs = 0;
      for (int c = 0; c < 200 && !hs; c++) begin
        @(negedge clk);
        if (done) hs = 1;
        else if (bready) bcnt++;
        @(posedge clk); #1;
      end
      if (!hs) fail_to("timeout_done");
      chk("timeout_cycles", bcnt, 64);
    end
    last_resp = exp_resp;
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [3:0] id,
                         input int nbeats, input logic [1:0] exp_resp, input bit exp_lerr);
    bit hs;
    push(2, {16'h0, id, len, addr});
    for (int i = 0; i < nbeats; i++) push(3, {23'h0, (i == nbeats - 1), rdv[i]});
    push(4, {28'h0, 1'b0, exp_lerr, exp_resp});
    issue_cmd(1'b0, addr, len, id);
    arready = 1'b1;
    hs = 0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = arvalid;
      @(posedge clk); #1;
    end
    arready = 1'b0;
    if (!hs) fail_to("ar_handshake");
    for (int i = 0; i < nbeats; i++) begin
      rvalid = 1'b1; rdata = rdv[i]; rresp = rrv[i]; rlast = (i == nbeats - 1); rid = id;
      hs = 0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clk);
        hs = rready;
        @(posedge clk); #1;
      end
      if (!hs) fail_to("r_beat");
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    wait_done("read_done");
    last_resp = exp_resp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_valids", {awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, rd_last}, 0);
    chk("reset_status", {done, resp, len_err, timeout}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic write: 3 beats, wlast on beat 3 only.
    wd[0] = 8'd1; wd[1] = 8'd2; wd[2] = 8'd1;
    do_write(8'h01, 4'd2, 4'd1, 0, 1'b0, 2'b00, 4'd1, 2'b00, -1, 1'b0);

    // Read with rresp 0,2,0: worst is 2.
    rdv[0] = 8'hA1; rdv[1] = 8'hA2; rdv[2] = 8'hA3;
    rrv[0] = 2'd0;  rrv[1] = 2'd2;  rrv[2] = 2'd0;
    do_read(8'h02, 4'd2, 4'd1, 3, 2'b10, 1'b0);

    // Early rlast on beat 2 of 3.
    rdv[0] = 8'hB1; rdv[1] = 8'hB2;
    rrv[0] = 2'd0;  rrv[1] = 2'd0;
    do_read(8'h03, 4'd2, 4'd1, 2, 2'b00, 1'b1);

    // Overrun: len=1 (2 beats) but rlast on beat 3.
    rdv[0] = 8'hC1; rdv[1] = 8'hC2; rdv[2] = 8'hC3;
    rrv[0] = 2'd1;  rrv[1] = 2'd0;  rrv[2] = 2'd1;
    do_read(8'h04, 4'd1, 4'd6, 3, 2'b01, 1'b1);

    // AW held off 5 cycles, wready toggling, bresp=1.
    wd[0] = 8'h11; wd[1] = 8'h12; wd[2] = 8'h13; wd[3] = 8'h14;
    do_write(8'h40, 4'd3, 4'd5, 5, 1'b1, 2'b01, 4'd5, 2'b01, -1, 1'b0);

    // Single beat, bid mismatch forces resp=2.
    wd[0] = 8'h5A;
    do_write(8'h7F, 4'd0, 4'd3, 0, 1'b0, 2'b00, 4'd4, 2'b10, -1, 1'b0);

    // Longest burst, 16 beats with backpressure.
    for (int i = 0; i < 16; i++) wd[i] = 8'(i * 17 + 3);
    do_write(8'h80, 4'd15, 4'hF, 0, 1'b1, 2'b00, 4'hF, 2'b00, -1, 1'b0);

    // 16-beat read, one beat with rresp=3.
    for (int i = 0; i < 16; i++) begin
      rdv[i] = 8'(8'hF0 - i);
      rrv[i] = (i == 7) ? 2'd3 : 2'd1;
    end
    do_read(8'h90, 4'd15, 4'h2, 16, 2'b11, 1'b0);

    // Reset during beat 2 of a write, then a normal write.
    wd[0] = 8'h21; wd[1] = 8'h22; wd[2] = 8'h23;
    do_write(8'h10, 4'd2, 4'd2, 0, 1'b0, 2'b00, 4'd2, 2'b00, 1, 1'b0);
    wd[0] = 8'h31; wd[1] = 8'h32;
    do_write(8'h05, 4'd1, 4'd2, 0, 1'b0, 2'b00, 4'd2, 2'b00, -1, 1'b0);

`ifdef AXI_TIMEOUT_EN
    // B never arrives: watchdog aborts 64 cycles into WRESP.
    wd[0] = 8'h41;
    do_write(8'h06, 4'd0, 4'd1, 0, 1'b0, 2'b00, 4'd1, 2'b11, -1, 1'b1);
`endif

    // Back-to-back read right after the previous done.
    rdv[0] = 8'h77; rrv[0] = 2'd0;
    do_read(8'h0A, 4'd0, 4'd9, 1, 2'b00, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter ADDR_W, default 8, address width.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 Parameter ID_W, default 4, transaction ID width.
REQ-004 Parameter TIMEOUT_CYC, default 64, watchdog limit in cycles; used only under AXI_TIMEOUT_EN.
REQ-005 Ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  in  1  1=write burst, 0=read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  4  beats-1 (AXI encoding, 1..16 beats).
- cmd_id  in  ID_W  transaction ID.
- wr_data/wr_valid/wr_ready  in/in/out  DATA_W/1/1  user write-data stream.
- rd_data/rd_valid/rd_last  out  DATA_W/1/1  user read-data stream, no backpressure.
- done  out  1  one-cycle pulse at burst end.
- resp  out  2  burst status, held until next done.
- len_err  out  1  read burst beat count mismatch, held until next done.
- timeout  out  1  watchdog abort flag, held until next done.
- AXI AW: awvalid out 1, awready in 1, awaddr out ADDR_W, awlen out 4, awid out ID_W.
- AXI W: wvalid out 1, wready in 1, wdata out DATA_W, wlast out 1.
- AXI B: bvalid in 1, bready out 1, bresp in 2, bid in ID_W.
- AXI AR: arvalid out 1, arready in 1, araddr out ADDR_W, arlen out 4, arid out ID_W.
- AXI R: rvalid in 1, rready out 1, rdata in DATA_W, rresp in 2, rlast in 1, rid in ID_W.

Function
REQ-006 FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA; one burst in flight at a time.
REQ-007 IDLE: cmd_ready=1; on cmd_valid, register addr/len/id/write, clear beat counter and worst-resp, go to WADDR (write) or RADDR (read).
REQ-008 WADDR: awvalid=1 with registered awaddr/awlen/awid stable until awready; awready sampled high -> WDATA.
REQ-009 WDATA: wvalid=wr_valid, wdata=wr_data, wr_ready=wready; wlast=1 when beat counter==len; beat counts on wvalid&&wready; last beat -> WRESP.
REQ-010 WRESP: bready=1; on bvalid, resp<=bresp, done=1 next cycle, -> IDLE; bid!=registered id sets resp=2'b10.
REQ-011 RADDR: arvalid=1 with stable araddr/arlen/arid until arready -> RDATA.
REQ-012 RDATA: rready=1; rd_valid=rvalid, rd_data=rdata, rd_last=rlast, all combinational; resp<=max(resp,rresp) per beat.
REQ-013 Read end: on rvalid&&rlast -> done, IDLE; len_err=1 if beat counter!=len at rlast; if counter reaches len without rlast, keep accepting until rlast and set len_err.
REQ-014 Valid signals never deassert before handshake; a handshake completes in the cycle valid&&ready are sampled high.
REQ-015 cmd_valid outside IDLE is ignored (cmd_ready=0); back-to-back commands accepted the cycle after done.
REQ-016 Beat counter is 5 bits and does not wrap in a legal burst; the address is not incremented internally (slave-side INCR).

Reset
REQ-017 rst low asynchronously forces IDLE and sets all valid/ready/last outputs, done, resp, len_err, timeout and the beat counter to 0, and cmd_ready to 1 after release.
REQ-018 Reset mid-burst abandons the transaction with no done pulse.

Configuration
REQ-019 Macro AXI_TIMEOUT_EN: when defined, a counter clears on any AXI handshake or state change and increments otherwise in non-IDLE states; at TIMEOUT_CYC it forces IDLE, drops all valids, done=1, resp=2'b11, timeout=1.
REQ-020 Without AXI_TIMEOUT_EN, no counter logic is present; timeout is tied 0 and the FSM waits indefinitely.

Verification
REQ-021 Write addr=0x01 len=2 id=1, data 1,2,1, awready/wready/bvalid immediate, bresp=0 -> 3 W beats, wlast only on beat 3, done pulse, resp=0.
REQ-022 Read addr=0x02 len=2 id=1, slave returns 3 beats with rlast on beat 3, rresp 0,2,0 -> rd_valid x3, done, resp=2, len_err=0.
REQ-023 Read len=2, slave asserts rlast on beat 2 -> done after beat 2, len_err=1.
REQ-024 Write with awready held low 5 cycles and wready toggling -> awaddr/wdata stable under backpressure, beats counted only on handshake.
REQ-025 rst low during WDATA beat 2 -> immediate IDLE, all valids 0, no done; a following command completes normally.
REQ-026 AXI_TIMEOUT_EN, TIMEOUT_CYC=64, bvalid never asserted -> done 64 cycles after the WRESP state is entered, resp=3, timeout=1.
